// File: rtl/hit_equation_evaluator.sv
// Builds "A op B" from collision hit pulses, checks it against the level target and keeps the score.
// Optional build macro HIT_EQ_TIMEOUT_EN adds a frame-based timeout while waiting for the next hit.
module hit_equation_evaluator #(
   parameter int NUMBERS        = 3,
   parameter int VALUE_W        = 4,
   parameter int RESULT_W       = 8,
   parameter int TIMEOUT_FRAMES = 150
) (
   input  logic                       clk,
   input  logic                       resetN,
   input  logic                       startOfFrame,
   input  logic [NUMBERS-1:0]         SingleHitPulse,
   input  logic [1:0]                 operandHit,
   input  logic [NUMBERS*VALUE_W-1:0] numberValues,
   input  logic [RESULT_W-1:0]        targetValue,
   input  logic                       roundClear,
   output logic [NUMBERS-1:0]         numberConsumed,
   output logic [1:0]                 operandConsumed,
   output logic                       correctPulse,
   output logic                       wrongPulse,
   output logic                       timeoutPulse,
   output logic [VALUE_W-1:0]         operandA,
   output logic [VALUE_W-1:0]         operandB,
   output logic                       opSel,
   output logic [RESULT_W-1:0]        resultValue,
   output logic [15:0]                score,
   output logic [2:0]                 roundState
);

   localparam int IDX_W = (NUMBERS > 1) ? $clog2(NUMBERS) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_OP = 3'd1,
      WAIT_B  = 3'd2,
      EVAL    = 3'd3,
      REPORT  = 3'd4
   } state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   a_idx;
   logic               underflow;
   logic               hit_any;
   logic [IDX_W-1:0]   hit_idx;
   logic [VALUE_W-1:0] hit_value;
   logic               capture_a, capture_op, capture_b, do_eval, do_report;
   logic               timeout_hit;

   function automatic logic [15:0] score_step(input logic [15:0] cur, input logic up);
      if (up) return (cur == 16'hFFFF) ? cur : cur + 16'd1;
      else    return (cur == 16'h0000) ? cur : cur - 16'd1;
   endfunction

   // Lowest-index eligible hit wins; in WAIT_B the captured A index is not eligible.
   always_comb begin
      hit_any = 1'b0;
      hit_idx = '0;
      for (int i = NUMBERS - 1; i >= 0; i--) begin
         if (SingleHitPulse[i] && !(state == WAIT_B && IDX_W'(i) == a_idx)) begin
            hit_any = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
      hit_value = numberValues[int'(hit_idx)*VALUE_W +: VALUE_W];
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      capture_a  = 1'b0;
      capture_op = 1'b0;
      capture_b  = 1'b0;
      do_eval    = 1'b0;
      do_report  = 1'b0;
      if (roundClear) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (hit_any) begin
               capture_a = 1'b1;
               state_nxt = WAIT_OP;
            end
            WAIT_OP: begin
               if (timeout_hit) begin
                  state_nxt = IDLE;
               end else if (operandHit != 2'b00) begin
                  capture_op = 1'b1;
                  state_nxt  = WAIT_B;
               end else if (hit_any) begin
                  capture_a = 1'b1;
               end
            end
            WAIT_B: begin
               if (timeout_hit) begin
                  state_nxt = IDLE;
               end else if (hit_any) begin
                  capture_b = 1'b1;
                  state_nxt = EVAL;
               end
            end
            EVAL: begin
               do_eval   = 1'b1;
               state_nxt = REPORT;
            end
            REPORT: begin
               do_report = 1'b1;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         numberConsumed  <= '0;
         operandConsumed <= '0;
         correctPulse    <= 1'b0;
         wrongPulse      <= 1'b0;
         operandA        <= '0;
         operandB        <= '0;
         opSel           <= 1'b0;
         resultValue     <= '0;
         underflow       <= 1'b0;
         score           <= '0;
         a_idx           <= '0;
      end else begin
         numberConsumed  <= '0;
         operandConsumed <= '0;
         correctPulse    <= 1'b0;
         wrongPulse      <= 1'b0;
         if (capture_a) begin
            operandA       <= hit_value;
            a_idx          <= hit_idx;
            numberConsumed <= NUMBERS'(1) << hit_idx;
         end
         if (capture_op) begin
            opSel           <= ~operandHit[0];
            operandConsumed <= operandHit[0] ? 2'b01 : 2'b10;
         end
         if (capture_b) begin
            operandB       <= hit_value;
            numberConsumed <= NUMBERS'(1) << hit_idx;
         end
         if (do_eval) begin
            if (opSel) begin
               underflow   <= (operandA < operandB);
               resultValue <= (operandA < operandB) ? '0
                              : RESULT_W'(operandA) - RESULT_W'(operandB);
            end else begin
               underflow   <= 1'b0;
               resultValue <= RESULT_W'(operandA) + RESULT_W'(operandB);
            end
         end
         if (do_report) begin
            if (!underflow && resultValue == targetValue) begin
               correctPulse <= 1'b1;
               score        <= score_step(score, 1'b1);
            end else begin
               wrongPulse <= 1'b1;
               score      <= score_step(score, 1'b0);
            end
         end
      end
   end

`ifdef HIT_EQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_FRAMES + 1);
   logic [CNT_W-1:0] frame_cnt;
   logic             in_wait, enter_wait;

   assign in_wait     = (state == WAIT_OP) || (state == WAIT_B);
   assign enter_wait  = (state_nxt != state) && (state_nxt == WAIT_OP || state_nxt == WAIT_B);
   assign timeout_hit = in_wait && startOfFrame && !roundClear
                        && (frame_cnt == CNT_W'(TIMEOUT_FRAMES - 1));

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         frame_cnt    <= '0;
         timeoutPulse <= 1'b0;
      end else begin
         timeoutPulse <= timeout_hit;
         if (enter_wait)                   frame_cnt <= '0;
         else if (in_wait && startOfFrame) frame_cnt <= frame_cnt + CNT_W'(1);
      end
   end
`else
   logic unused_sof;
   assign unused_sof   = startOfFrame & (TIMEOUT_FRAMES > 0);
   assign timeout_hit  = 1'b0;
   assign timeoutPulse = 1'b0;
`endif

   assign roundState = state;

endmodule

// File: tb/tb_hit_equation_evaluator.sv
// Scoreboard bench for hit_equation_evaluator: stimulus queues expected pulses, a monitor pops and compares.
module tb_hit_equation_evaluator;

   logic        clk = 1'b0;
   logic        resetN;
   logic        startOfFrame;
   logic [2:0]  SingleHitPulse;
   logic [1:0]  operandHit;
   logic [11:0] numberValues;
   logic [7:0]  targetValue;
   logic        roundClear;
   logic [2:0]  numberConsumed;
   logic [1:0]  operandConsumed;
   logic        correctPulse, wrongPulse, timeoutPulse;
   logic [3:0]  operandA, operandB;
   logic        opSel;
   logic [7:0]  resultValue;
   logic [15:0] score;
   logic [2:0]  roundState;

   hit_equation_evaluator #(
      .NUMBERS(3), .VALUE_W(4), .RESULT_W(8), .TIMEOUT_FRAMES(4)
   ) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .SingleHitPulse(SingleHitPulse), .operandHit(operandHit),
      .numberValues(numberValues), .targetValue(targetValue), .roundClear(roundClear),
      .numberConsumed(numberConsumed), .operandConsumed(operandConsumed),
      .correctPulse(correctPulse), .wrongPulse(wrongPulse), .timeoutPulse(timeoutPulse),
      .operandA(operandA), .operandB(operandB), .opSel(opSel),
      .resultValue(resultValue), .score(score), .roundState(roundState)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2:0]  nc;
      logic [1:0]  oc;
      logic        cor, wr, to;
      logic        chk_res;
      logic [7:0]  res;
      logic [15:0] scr;
      int          due;
   } ev_t;

   ev_t         q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [15:0] model_score = 16'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_ev(input logic [2:0] nc, input logic [1:0] oc, input logic cor,
                            input logic wr, input logic to, input int lat,
                            input logic chk_res, input logic [7:0] res);
      ev_t e;
      e.nc = nc; e.oc = oc; e.cor = cor; e.wr = wr; e.to = to;
      e.chk_res = chk_res; e.res = res; e.scr = model_score; e.due = cyc + lat;
      q.push_back(e);
   endtask

   // Monitor: every pulse the DUT shows must match the oldest queued expectation on its due cycle.
   always @(negedge clk) begin
      if (resetN === 1'b1) begin
         if (q.size() > 0 && q[0].due < cyc) begin
            checks++;
            failures++;
            $display("FAIL missed_event actual=none expected_due=%0d (cycle %0d)", q[0].due, cyc);
            void'(q.pop_front());
         end
         if (numberConsumed != 0 || operandConsumed != 0 || correctPulse || wrongPulse || timeoutPulse) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_pulse actual=%b_%b_%b%b%b expected=none (cycle %0d)",
                        numberConsumed, operandConsumed, correctPulse, wrongPulse, timeoutPulse, cyc);
            end else begin
               ev_t e;
               e = q.pop_front();
               check("pulses", {24'd0, numberConsumed, operandConsumed, correctPulse, wrongPulse, timeoutPulse},
                     {24'd0, e.nc, e.oc, e.cor, e.wr, e.to});
               check("pulse_cycle", cyc, e.due);
               if (e.chk_res) begin
                  check("resultValue", {24'd0, resultValue}, {24'd0, e.res});
                  check("score", {16'd0, score}, {16'd0, e.scr});
               end
            end
         end
      end
   end

   // Apply one clock's worth of inputs from a negedge; returns at the following negedge.
   task automatic drive(input logic [2:0] nums, input logic [1:0] ops, input logic clr, input logic sof);
      SingleHitPulse = nums; operandHit = ops; roundClear = clr; startOfFrame = sof;
      @(negedge clk);
      SingleHitPulse = '0; operandHit = '0; roundClear = 1'b0; startOfFrame = 1'b0;
   endtask

   task automatic hit_a(input logic [2:0] nums, input logic [2:0] nc);
      expect_ev(nc, 2'b00, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'd0);
      drive(nums, 2'b00, 1'b0, 1'b0);
      check("state_after_a", {29'd0, roundState}, 32'd1);
   endtask

   task automatic hit_op(input logic [1:0] ops, input logic [1:0] oc, input logic sel);
      expect_ev(3'b000, oc, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'd0);
      drive(3'b000, ops, 1'b0, 1'b0);
      check("state_after_op", {29'd0, roundState}, 32'd2);
      check("opSel", {31'd0, opSel}, {31'd0, sel});
   endtask

   task automatic hit_b_report(input logic [2:0] nums, input logic [2:0] nc, input logic cor, input logic [7:0] res);
      expect_ev(nc, 2'b00, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'd0);
      if (cor) model_score = (model_score == 16'hFFFF) ? model_score : model_score + 16'd1;
      else     model_score = (model_score == 16'h0000) ? model_score : model_score - 16'd1;
      expect_ev(3'b000, 2'b00, cor, ~cor, 1'b0, 3, 1'b1, res);
      drive(nums, 2'b00, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      check("state_after_report", {29'd0, roundState}, 32'd0);
   endtask

   initial begin
      resetN = 1'b0; startOfFrame = 1'b0; SingleHitPulse = '0; operandHit = '0;
      roundClear = 1'b0; numberValues = 12'h753; targetValue = 8'd8;
      repeat (3) @(negedge clk);
      check("reset_state", {29'd0, roundState}, 32'd0);
      check("reset_score", {16'd0, score}, 32'd0);
      check("reset_result", {24'd0, resultValue}, 32'd0);
      resetN = 1'b1;
      @(negedge clk);

      // operandHit in IDLE is ignored
      drive(3'b000, 2'b01, 1'b0, 1'b0);
      check("idle_op_ignored", {29'd0, roundState}, 32'd0);

      // 3 - 7 underflows: result 0, wrong, score saturates at 0
      targetValue = 8'd0;
      hit_a(3'b001, 3'b001);
      check("operandA_3", {28'd0, operandA}, 32'd3);
      hit_op(2'b10, 2'b10, 1'b1);
      hit_b_report(3'b100, 3'b100, 1'b0, 8'd0);

      // 3 + 5 = 8 correct
      targetValue = 8'd8;
      hit_a(3'b001, 3'b001);
      hit_op(2'b01, 2'b01, 1'b0);
      hit_b_report(3'b010, 3'b010, 1'b1, 8'd8);
      check("operandB_5", {28'd0, operandB}, 32'd5);

      // re-hit of A index ignored, then 110 picks idx1
      hit_a(3'b001, 3'b001);
      hit_op(2'b01, 2'b01, 1'b0);
      drive(3'b001, 2'b00, 1'b0, 1'b0);
      check("rehit_a_ignored", {29'd0, roundState}, 32'd2);
      hit_b_report(3'b110, 3'b010, 1'b1, 8'd8);

      // replace A with idx2, both operands -> add wins; 7 + 5 = 12 wrong
      hit_a(3'b001, 3'b001);
      hit_a(3'b100, 3'b100);
      check("operandA_replaced", {28'd0, operandA}, 32'd7);
      hit_op(2'b11, 2'b01, 1'b0);
      hit_b_report(3'b010, 3'b010, 1'b0, 8'd12);

      // roundClear together with a B hit: abort wins, no pulses, score and A kept
      hit_a(3'b001, 3'b001);
      hit_op(2'b10, 2'b10, 1'b1);
      drive(3'b010, 2'b00, 1'b1, 1'b0);
      check("clear_state", {29'd0, roundState}, 32'd0);
      check("clear_score", {16'd0, score}, {16'd0, model_score});
      check("clear_holdA", {28'd0, operandA}, 32'd3);
      repeat (3) @(negedge clk);

      // 7 - 5 = 2 correct
      targetValue = 8'd2;
      hit_a(3'b100, 3'b100);
      hit_op(2'b10, 2'b10, 1'b1);
      hit_b_report(3'b010, 3'b010, 1'b1, 8'd2);
      check("score_after_sub", {16'd0, score}, 32'd2);

      // reset while in EVAL clears everything immediately
      hit_a(3'b001, 3'b001);
      hit_op(2'b01, 2'b01, 1'b0);
      expect_ev(3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'd0);
      drive(3'b010, 2'b00, 1'b0, 1'b0);
      check("in_eval", {29'd0, roundState}, 32'd3);
      #2 resetN = 1'b0;
      #1;
      model_score = 16'd0;
      check("rst_eval_state", {29'd0, roundState}, 32'd0);
      check("rst_eval_score", {16'd0, score}, 32'd0);
      check("rst_eval_ops", {24'd0, operandA, operandB}, 32'd0);
      check("rst_eval_consumed", {29'd0, numberConsumed}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      resetN = 1'b1;
      @(negedge clk);

      // frame timeout while waiting for the operator
      hit_a(3'b001, 3'b001);
      repeat (3) drive(3'b000, 2'b00, 1'b0, 1'b1);
`ifdef HIT_EQ_TIMEOUT_EN
      expect_ev(3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1, 1'b0, 8'd0);
      drive(3'b000, 2'b00, 1'b0, 1'b1);
      check("timeout_state", {29'd0, roundState}, 32'd0);
      check("timeout_score", {16'd0, score}, 32'd0);
`else
      drive(3'b000, 2'b00, 1'b0, 1'b1);
      check("no_timeout_state", {29'd0, roundState}, 32'd1);
      drive(3'b000, 2'b00, 1'b1, 1'b0);
`endif
      repeat (4) @(negedge clk);
      check("queue_drained", q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
